// File: rtl/spi_flash_reader.sv
// READ (0x03) sequencer for an SPI NOR flash in mode 0.
// One start runs: 8-bit command, 24-bit address, N data bytes, then an SS-high guard.
module spi_flash_reader #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    // start is taken on any cycle with busy=0; done pulses on the cycle busy
    // falls, so a start held high chains transactions back to back. rd_valid
    // has no ready: every strobe must be consumed in the cycle it appears.
    input  logic        start,
    input  logic [23:0] addr,
    input  logic [7:0]  len,
    output logic        busy,
    output logic        done,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    output logic        spi_ss,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GUARD = 2'd2
    } state_e;

    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [8:0] GUARD_LAST = 9'(2 * CLK_DIV - 2);

    state_e      state_q, state_d;
    logic [7:0]  div_cnt_q, div_cnt_d;
    logic [11:0] bit_cnt_q, bit_cnt_d;
    logic [11:0] last_bit_q, last_bit_d;
    logic [8:0]  guard_cnt_q, guard_cnt_d;
    logic [31:0] tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;
    logic        byte_done_q, byte_done_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        rd_valid_q, rd_valid_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        ss_q, ss_d;
    logic        sck_q, sck_d;
    logic        mosi_q, mosi_d;

    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        last_bit_d  = last_bit_q;
        guard_cnt_d = guard_cnt_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        byte_done_d = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        ss_d        = ss_q;
        sck_d       = sck_q;
        mosi_d      = mosi_q;
        // A byte completed on the previous cycle is published one cycle later.
        rd_valid_d  = byte_done_q;
        rd_data_d   = byte_done_q ? rx_q : rd_data_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                ss_d   = 1'b1;
                sck_d  = 1'b0;
                mosi_d = 1'b0;
                if (start) begin
                    state_d    = SHIFT;
                    busy_d     = 1'b1;
                    ss_d       = 1'b0;
                    tx_d       = {8'h03, addr};
                    mosi_d     = tx_d[31];
                    // len 0 reads 256 bytes: the extra top bit makes 9'h100.
                    last_bit_d = 12'd31 + {(len == 8'd0), len, 3'b000};
                    bit_cnt_d  = '0;
                    div_cnt_d  = '0;
                end
            end

            SHIFT: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    if (!sck_q) begin
                        sck_d       = 1'b1;
                        rx_d        = {rx_q[6:0], spi_miso};
                        byte_done_d = (bit_cnt_q >= 12'd32) && (bit_cnt_q[2:0] == 3'd7);
                    end else begin
                        sck_d  = 1'b0;
                        tx_d   = {tx_q[30:0], 1'b0};
                        mosi_d = tx_d[31];
                        if (bit_cnt_q == last_bit_q) begin
                            state_d     = GUARD;
                            ss_d        = 1'b1;
                            mosi_d      = 1'b0;
                            guard_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 12'd1;
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end

            GUARD: begin
                // The last guard cycle is spent back in IDLE with done high.
                if (guard_cnt_q == GUARD_LAST) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    guard_cnt_d = guard_cnt_q + 9'd1;
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                ss_d    = 1'b1;
                sck_d   = 1'b0;
                mosi_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            div_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            last_bit_q  <= '0;
            guard_cnt_q <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            byte_done_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            ss_q        <= 1'b1;
            sck_q       <= 1'b0;
            mosi_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            last_bit_q  <= last_bit_d;
            guard_cnt_q <= guard_cnt_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            byte_done_q <= byte_done_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            ss_q        <= ss_d;
            sck_q       <= sck_d;
            mosi_q      <= mosi_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign spi_ss    = ss_q;
    assign spi_sck   = sck_q;
    assign spi_mosi  = mosi_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: three instances (CLK_DIV 2, 1, 3) share one flash model
// and monitor, muxed by the instance currently under test.
module tb_spi_flash_reader;

    function automatic int div_of(input int i);
        div_of = (i == 0) ? 2 : ((i == 1) ? 1 : 3);
    endfunction

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [2:0] start;
    logic [23:0] addr;
    logic [7:0] len;
    logic       miso_bit;
    logic [2:0] busy, done, rd_valid, ss, sck, mosi;
    logic [7:0] rd_data [3];
    logic [1:0] dbg_state [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int DIV = div_of(g);
        spi_flash_reader #(.CLK_DIV(DIV)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start[g]),
            .addr      (addr),
            .len       (len),
            .busy      (busy[g]),
            .done      (done[g]),
            .rd_valid  (rd_valid[g]),
            .rd_data   (rd_data[g]),
            .spi_ss    (ss[g]),
            .spi_sck   (sck[g]),
            .spi_mosi  (mosi[g]),
            .spi_miso  (miso_bit),
            .dbg_state (dbg_state[g])
        );
    end

    logic [1:0] cur;
    int         dcur;
    logic       a_ss, a_sck, a_mosi, a_busy, a_done, a_rv;
    logic [7:0] a_rd_data;
    always_comb begin
        dcur      = div_of(int'(cur));
        a_ss      = ss[cur];
        a_sck     = sck[cur];
        a_mosi    = mosi[cur];
        a_busy    = busy[cur];
        a_done    = done[cur];
        a_rv      = rd_valid[cur];
        a_rd_data = rd_data[cur];
    end

    // ---------------- clock counter / scoreboard state ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];
    int t0, nb, bj;
    bit aborted;
    logic [7:0] pat_base, pat_step;
    int n_done, n_rv, n_fall, n_rise, ph_err, mosi_err;
    int first_done_cyc, last_done_cyc, last_rise_cyc, last_fall_cyc;
    int rises, run, lc;
    logic [31:0] mosi_word;
    logic prev_ss = 1'b1, prev_sck = 1'b0, prev_mosi = 1'b0;
    logic mb;
    int mn;
    logic [7:0] mbyte, ebyte;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pat_byte(input int j);
        pat_byte = pat_base + 8'(j) * pat_step;
    endfunction

    // ---------------- monitor + flash model ----------------
    always @(negedge clk) begin
        if (!a_ss && prev_ss) begin
            n_fall++;
            last_fall_cyc = cyc;
            check("ss_fall_cyc", cyc, t0 + 1);
            run = 0;
            mosi_word = '0;
        end
        if (a_ss && !prev_ss && !aborted) begin
            last_rise_cyc = cyc;
            check("ss_rise_cyc", cyc, t0 + 1 + 2 * dcur * nb);
            if (run != dcur) ph_err++;
        end
        if (!a_ss) begin
            if (prev_ss || a_sck == prev_sck) run++;
            else begin
                if (run != dcur) ph_err++;
                run = 1;
            end
            if (!prev_ss && a_mosi !== prev_mosi && a_sck) mosi_err++;
            if (a_sck && !prev_sck) begin
                if (rises < 32) mosi_word = {mosi_word[30:0], a_mosi};
                rises++;
                n_rise++;
            end
        end
        if (a_done) begin
            n_done++;
            if (n_done == 1) first_done_cyc = cyc;
            last_done_cyc = cyc;
            check("done_cyc", cyc, t0 + 2 * dcur * (nb + 1));
            check("busy_at_done", 32'(a_busy), 0);
            t0 = t0 + 2 * dcur * (nb + 1);
            bj = 0;
        end
        if (a_rv) begin
            n_rv++;
            if (exp_q.size() == 0) check("rd_valid_unexpected", 1, 0);
            else begin
                ebyte = exp_q.pop_front();
                check("rd_data", 32'(a_rd_data), 32'(ebyte));
                check("rd_valid_cyc", cyc, t0 + 2 + 2 * dcur * (39 + 8 * bj) + dcur);
                bj++;
            end
        end
        // Flash drives the next bit, inverted everywhere except the last low cycle.
        if (a_ss) begin
            lc = 0;
            rises = 0;
            miso_bit = 1'($urandom_range(0, 1));
        end else begin
            if (rises < 32) mb = 1'($urandom_range(0, 1));
            else begin
                mn = rises - 32;
                mbyte = pat_byte(mn / 8);
                mb = mbyte[7 - (mn % 8)];
            end
            if (!a_sck) begin
                miso_bit = (lc == dcur - 1) ? mb : ~mb;
                lc++;
            end else begin
                lc = 0;
                miso_bit = ~mb;
            end
        end
        prev_ss = a_ss;
        prev_sck = a_sck;
        prev_mosi = a_mosi;
    end

    // ---------------- driver tasks ----------------
    task automatic clear_stats();
        n_done = 0; n_rv = 0; n_fall = 0; n_rise = 0; ph_err = 0; mosi_err = 0;
    endtask

    task automatic start_txn(input logic [1:0] inst, input logic [23:0] a,
                             input logic [7:0] l, input bit hold, input int copies);
        int lb;
        @(negedge clk);
        cur = inst;
        addr = a;
        len = l;
        start[inst] = 1'b1;
        t0 = cyc;
        lb = (l == 8'd0) ? 256 : int'(l);
        nb = 32 + 8 * lb;
        bj = 0;
        aborted = 1'b0;
        for (int c = 0; c < copies; c++)
            for (int j = 0; j < lb; j++) exp_q.push_back(pat_byte(j));
        if (!hold) begin
            @(negedge clk);
            start = '0;
        end
    endtask

    task automatic wait_done(input int target, input int budget);
        int k = 0;
        while (n_done < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        check("done_count", n_done, target);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int t1, k, seen;
        rst = 1'b1; start = '0; addr = '0; len = '0; cur = 2'd0;
        t0 = 0; nb = 40; bj = 0; aborted = 1'b0;
        pat_base = 8'h00; pat_step = 8'h00;
        rises = 0; run = 0; lc = 0; mosi_word = '0;
        first_done_cyc = 0; last_done_cyc = 0; last_rise_cyc = 0; last_fall_cyc = 0;
        clear_stats();
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_ss", 32'(ss), 32'h7);
        check("rst_sck", 32'(sck), 0);
        check("rst_mosi", 32'(mosi), 0);
        for (int i = 0; i < 3; i++) begin
            check("rst_rd_data", 32'(rd_data[i]), 0);
            check("rst_state", 32'(dbg_state[i]), 0);
        end
        rst = 1'b0;

        // Single byte read at CLK_DIV=2
        pat_base = 8'hA5; pat_step = 8'h00;
        clear_stats();
        start_txn(2'd0, 24'h123456, 8'd1, 1'b0, 1);
        t1 = t0;
        wait_done(1, 400);
        check("t1_mosi_header", mosi_word, 32'h03123456);
        check("t1_rv_count", n_rv, 1);
        check("t1_rises", n_rise, 40);
        check("t1_ss_rise", last_rise_cyc - t1, 161);
        check("t1_done", last_done_cyc - t1, 164);
        check("t1_phase", ph_err, 0);
        check("t1_q_empty", exp_q.size(), 0);

        // 256-byte read at CLK_DIV=1
        pat_base = 8'h00; pat_step = 8'h01;
        clear_stats();
        start_txn(2'd1, 24'hABCDEF, 8'd0, 1'b0, 1);
        wait_done(1, 6000);
        check("t2_mosi_header", mosi_word, 32'h03ABCDEF);
        check("t2_rv_count", n_rv, 256);
        check("t2_rises", n_rise, 2080);
        check("t2_phase", ph_err, 0);
        check("t2_mosi_stable", mosi_err, 0);
        check("t2_q_empty", exp_q.size(), 0);

        // start held high: exactly two back-to-back transactions
        pat_base = 8'($urandom); pat_step = 8'h03;
        clear_stats();
        start_txn(2'd0, 24'($urandom), 8'd1, 1'b1, 2);
        k = 0; seen = 0;
        while (seen < 2 && k < 1000) begin
            @(negedge clk);
            k++;
            if (a_done) seen++;
        end
        start = '0;
        repeat (20) @(negedge clk);
        check("t3_done_count", n_done, 2);
        check("t3_fall_count", n_fall, 2);
        check("t3_gap", last_fall_cyc - first_done_cyc, 1);
        check("t3_rv_count", n_rv, 2);
        check("t3_q_empty", exp_q.size(), 0);

        // reset during bit 36
        pat_base = 8'h5A; pat_step = 8'h01;
        clear_stats();
        start_txn(2'd0, 24'($urandom), 8'd2, 1'b0, 1);
        k = 0;
        while (cyc < t0 + 1 + 4 * 36 + 1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        rst = 1'b1;
        aborted = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("t4_ss", 32'(a_ss), 1);
        check("t4_sck", 32'(a_sck), 0);
        check("t4_busy", 32'(a_busy), 0);
        check("t4_mosi", 32'(a_mosi), 0);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check("t4_no_done", n_done, 0);
        check("t4_no_rd_valid", n_rv, 0);
        clear_stats();
        start_txn(2'd0, 24'h000100, 8'd1, 1'b0, 1);
        wait_done(1, 400);
        check("t4_restart_rv", n_rv, 1);
        check("t4_restart_header", mosi_word, 32'h03000100);
        check("t4_q_empty", exp_q.size(), 0);

        // CLK_DIV=3, two bytes, MISO inverted between sample points
        pat_base = 8'($urandom); pat_step = 8'h11;
        clear_stats();
        start_txn(2'd2, 24'($urandom), 8'd2, 1'b0, 1);
        wait_done(1, 1000);
        check("t5_phase", ph_err, 0);
        check("t5_mosi_stable", mosi_err, 0);
        check("t5_rises", n_rise, 48);
        check("t5_rv_count", n_rv, 2);
        check("t5_q_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_flash_reader.md
# spi_flash_reader

Sequencing controller for the iCE40 SPI flash port. It owns `ICE_SS`, `ICE_SCK` and `ICE_MOSI` and samples `ICE_MISO`. On a start request it runs one complete READ (0x03) transaction: an 8-bit command, a 24-bit address, then N data bytes. It streams each received byte out as a one-cycle valid strobe. It replaces ad-hoc free-running shift/counter experiments with a single start/busy/done-handshaked engine on the fast system clock.

## Interface
Parameters:
- `CLK_DIV`, default 4: `clk` cycles per SCK half-period; legal range 1..255.

Ports:
- `clk`  in  1  system clock (HFOSC domain); all logic is single clock.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  request a transaction; sampled only while `busy`=0.
- `addr`  in  24  flash byte address; captured on an accepted start.
- `len`  in  8  number of bytes to read; 0 means 256. Captured on an accepted start.
- `busy`  out  1  transaction in progress, including the SS-high guard time.
- `done`  out  1  one-cycle pulse when the transaction completes.
- `rd_valid`  out  1  one-cycle pulse per received data byte.
- `rd_data`  out  8  received byte; valid while `rd_valid`=1, held otherwise.
- `spi_ss`  out  1  chip select, active-low.
- `spi_sck`  out  1  serial clock, SPI mode 0 (idles low).
- `spi_mosi`  out  1  serial data to flash, MSB first.
- `spi_miso`  in  1  serial data from flash.

## Operation
- Reset values (all outputs registered): `busy`=0, `done`=0, `rd_valid`=0, `rd_data`=0x00, `spi_ss`=1, `spi_sck`=0, `spi_mosi`=0. Internal state returns to IDLE.
- States: IDLE -> SHIFT -> GUARD -> IDLE.
- IDLE:
  - On `start`=1, capture `addr` and `len`.
  - Load the 32-bit TX word {0x03, addr}.
  - Set bit count NB = 32 + 8*len (len 0 counts as 256; max NB = 2080, 12-bit counter).
  - Enter SHIFT.
- SHIFT, per bit:
  - Low phase: `spi_sck`=0 for CLK_DIV cycles, with `spi_mosi` = current TX MSB.
  - High phase: `spi_sck`=1 for CLK_DIV cycles.
  - On the cycle SCK goes 0->1, `spi_miso` is shifted into an 8-bit RX register (LSB in, MSB first).
  - On the cycle SCK goes 1->0, TX shifts left with 0 fill. After the 32 header bits `spi_mosi` stays 0.
  - Only bits 32..NB-1 are assembled into bytes. Header-phase MISO is discarded.
  - When the 8th bit of a data byte is sampled, `rd_data` and `rd_valid`=1 update on the following cycle, for one cycle only. There is no backpressure; the consumer must accept every strobe.
- When the last bit's high phase ends:
  - `spi_sck`=0 and `spi_ss`=1 in the same cycle.
  - Enter GUARD.
- GUARD:
  - `spi_ss` stays high for 2*CLK_DIV cycles (flash tSHSL).
  - In the final cycle, `done`=1 and `busy` drops to 0 together. State returns to IDLE.
- `start` while `busy`=1 is ignored, not queued.
- `start` in the same cycle `done`=1 is accepted, because `busy` is 0 on that cycle.
- `rst` mid-transaction: all outputs take their reset values on the next cycle. SS rises immediately, no `done` is produced, and a partial byte is discarded.

## Timing
- T0 is the cycle with an accepted `start`.
- T0+1: `busy`=1, `spi_ss`=0, `spi_sck`=0, `spi_mosi`=0 (0x03 MSB).
- Bit k (0-based):
  - Low phase starts at T0+1+2*CLK_DIV*k.
  - SCK rises (MISO sampled) at T0+1+2*CLK_DIV*k+CLK_DIV.
  - SCK falls at T0+1+2*CLK_DIV*(k+1).
- `spi_ss` rises at T0+1+2*CLK_DIV*NB.
- `done` pulses at T0+2*CLK_DIV*(NB+1), the last of the 2*CLK_DIV guard cycles. `busy` is 0 on that same cycle.
- Data byte j: `rd_valid` at T0+2+2*CLK_DIV*(32+8j+7)+CLK_DIV.
- SCK duty is exactly 50%. No glitches on SS/SCK/MOSI, since all come from flops.

## Test plan
- CLK_DIV=2, addr=0x123456, len=1, flash model returns 0xA5:
  - MOSI over 32 rising edges = 0x03123456.
  - One `rd_valid` with `rd_data`=0xA5.
  - `spi_ss` high at T0+161; `done` at T0+164.
- CLK_DIV=1, len=0, model returns an incrementing pattern from 0x00:
  - Exactly 256 `rd_valid` pulses with data 0x00..0xFF.
  - 2080 SCK rising edges; `done` once.
- `start` held high through a whole transaction:
  - Only one transaction runs while busy.
  - A second transaction begins at T0+1 after the `done` cycle, since back-to-back start is accepted when `busy`=0.
- `rst` asserted mid-data-byte (bit 36):
  - Next cycle `spi_ss`=1, `spi_sck`=0, `busy`=0.
  - No `done` and no `rd_valid`.
  - A subsequent start runs normally.
- CLK_DIV=3, len=2:
  - Each SCK high and low phase measures exactly 3 cycles.
  - MOSI changes only while SCK is low.
  - MISO is sampled only on rising edges, checked by inverting MISO between edges to prove sample timing.
